uart_tx_feeder: RTL

Byte-wide transmit buffer and sequencer that sits directly upstream of the UART transmitter. The host pushes bytes into an internal FIFO. The feeder pops them one at a time and presents each on the UART's parallel byte input. It then drives the UART chip-select/read strobes for the load cycle plus eight shift cycles, so the UART shifts the byte out on its serial pin.

---
 rtl/uart_tx_feeder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus LOAD/SHIFT sequencer that drives the UART parallel load and strobe pins.
// Optional sticky overflow flag: define UART_TXF_OVF_STICKY_EN to build it.
module uart_tx_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk0,
  input  logic          reset,
  input  logic          host_wr,
  input  logic [7:0]    host_wdata,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic [AW:0]   fifo_count,
  output logic          tx_busy,
  output logic          uart_cs,
  output logic          uart_rd,
  output logic          uart_wr,
  output logic [7:0]    uart_datain,
  input  logic          ovf_clr,
  output logic          ovf,
  output logic [1:0]    dbg_state
);

  // Handshake: host_wr is a fire-and-forget push; it is accepted on any rising
  // edge where fifo_full is low and silently dropped otherwise (no ready/retry).

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_e;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      datain_q, datain_d;
  logic [7:0]      mem_q [DEPTH];

  logic            push_ok;
  logic            pop;
  logic            last_shift;

  assign fifo_count  = count_q;
  assign fifo_full   = (count_q == FULL_CNT);
  assign fifo_empty  = (count_q == '0);
  assign tx_busy     = (state_q != S_IDLE);
  assign uart_cs     = tx_busy;
  assign uart_rd     = tx_busy;
  assign uart_wr     = 1'b0;
  assign uart_datain = datain_q;
  assign dbg_state   = state_q;

  assign push_ok    = host_wr && !fifo_full;
  assign last_shift = (state_q == S_SHIFT) && (bit_cnt_q == 3'd7);
  // A pop is only ever taken on the edge that enters LOAD.
  assign pop        = !fifo_empty && ((state_q == S_IDLE) || last_shift);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_LOAD;
      end
      S_LOAD: begin
        bit_cnt_d = 3'd0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (last_shift) state_d = pop ? S_LOAD : S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = 3'd0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    datain_d = datain_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      datain_d = mem_q[rd_ptr_q];
    end
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      datain_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      datain_q  <= datain_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk0) begin
    if (push_ok) mem_q[wr_ptr_q] <= host_wdata;
  end

`ifdef UART_TXF_OVF_STICKY_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr)             ovf_d = 1'b0;
    if (host_wr && fifo_full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf            = 1'b0;
`endif

endmodule
